// File: rtl/seq_mul_signed.sv
`timescale 1ns/1ps
// Multi-cycle shift-add multiplier: a single 2*NUM_BITS adder walks the multiplier bits,
// and the sign is applied once at the end. Operands are taken as either unsigned or two's-complement.
module seq_mul_signed #(
  parameter int NUM_BITS = 16,
  parameter int CNT_BITS = 5
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    iStart,
  input  logic                    iSigned,
  input  logic [NUM_BITS-1:0]     iA,
  input  logic [NUM_BITS-1:0]     iB,
  output logic                    oReady,
  output logic                    oDone,
  output logic [2*NUM_BITS-1:0]   oResult
);

  localparam int PW = 2*NUM_BITS;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_BITS-1);
  localparam logic [NUM_BITS-1:0] ONE_N    = NUM_BITS'(1);
  localparam logic [PW-1:0]       ONE_P    = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_done;
  logic [PW-1:0]        r_result;
  logic [NUM_BITS-1:0]  r_mag_a;
  logic [NUM_BITS-1:0]  r_mag_b;
  logic                 r_neg;
  logic [PW-1:0]        r_acc;
  logic [CNT_BITS-1:0]  r_cnt;

  logic [NUM_BITS-1:0]  w_mag_a;
  logic [NUM_BITS-1:0]  w_mag_b;
  logic [NUM_BITS-1:0]  w_b_sh;
  logic [PW-1:0]        w_addend;
  logic [PW-1:0]        w_acc_nxt;
  logic [PW-1:0]        w_acc_neg;

  // -2^(N-1) negates to itself, which read as unsigned is exactly its magnitude
  assign w_mag_a   = (iSigned & iA[NUM_BITS-1]) ? (~iA + ONE_N) : iA;
  assign w_mag_b   = (iSigned & iB[NUM_BITS-1]) ? (~iB + ONE_N) : iB;
  assign w_b_sh    = r_mag_b >> r_cnt;
  assign w_addend  = {{NUM_BITS{1'b0}}, r_mag_a} << r_cnt;
  assign w_acc_nxt = w_b_sh[0] ? (r_acc + w_addend) : r_acc;
  assign w_acc_neg = ~r_acc + ONE_P;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state <= S_CALC;
            r_ready <= 1'b0;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= iSigned & (iA[NUM_BITS-1] ^ iB[NUM_BITS-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= S_FIX;
        end
        S_FIX: begin
          // negating a zero accumulator yields zero, so no "-0" case exists
          r_result <= r_neg ? w_acc_neg : r_acc;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign oReady  = r_ready;
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule
